// File: rtl/zigzag_buffer.sv
// zigzag_buffer: double-buffered 8x8 coefficient store; accepts raster rows and
// streams each block one coefficient per cycle in JPEG zigzag order.
module zigzag_buffer #(
    parameter int COEFF_W = 10,
    parameter int ROWS    = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*COEFF_W-1:0] in_row,
    input  logic                 in_luma,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [COEFF_W-1:0]   out_coeff,
    output logic [5:0]           out_index,
    output logic                 out_last,
    output logic                 out_luma
);
    localparam int ZZ [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    logic [COEFF_W-1:0] bank [2][64];
    logic [1:0]         full;
    logic [1:0]         luma;
    logic               wr_bank;
    logic               rd_bank;
    logic [2:0]         wr_row;
    logic [5:0]         rd_idx;
    logic               wr_en;
    logic               rd_en;

    // Handshakes only ever touch different banks, so full[] set/clear never collide.
    always_comb begin
        in_ready  = !full[wr_bank];
        out_valid = full[rd_bank];
        wr_en     = in_valid && in_ready;
        rd_en     = out_valid && out_ready;
        out_coeff = bank[rd_bank][6'(ZZ[rd_idx])];
        out_index = rd_idx;
        out_last  = rd_idx == 6'd63;
        out_luma  = luma[rd_bank];
    end

    always_ff @(posedge clock)
        if (wr_en)
            for (int k = 0; k < 8; k++)
                bank[wr_bank][{wr_row, 3'(k)}] <= in_row[k*COEFF_W +: COEFF_W];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            full    <= '0;
            luma    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_row  <= '0;
            rd_idx  <= '0;
        end else begin
            if (wr_en) begin
                if (wr_row == 3'd0)
                    luma[wr_bank] <= in_luma;
                wr_row <= wr_row + 3'd1;
                if (wr_row == 3'(ROWS-1)) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                end
            end
            if (rd_en) begin
                rd_idx <= rd_idx + 6'd1;
                if (rd_idx == 6'd63) begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= ~rd_bank;
                end
            end
        end
    end
endmodule

// File: tb/tb_zigzag_buffer.sv
// tb_zigzag_buffer: directed table-driven and sequence checks of zigzag_buffer.
module tb_zigzag_buffer;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [79:0] in_row = '0;
    logic        in_luma = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [9:0]  out_coeff;
    logic [5:0]  out_index;
    logic        out_last;
    logic        out_luma;
    int checks = 0;
    int passes = 0;

    localparam int ZZ [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    typedef struct {
        logic       rdy;
        logic [9:0] coeff;
        logic [5:0] idx;
        logic       last;
    } vec_t;
    vec_t tbl [$];

    always #5 clock = ~clock;

    zigzag_buffer dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row), .in_luma(in_luma),
        .out_valid(out_valid), .out_ready(out_ready), .out_coeff(out_coeff),
        .out_index(out_index), .out_last(out_last), .out_luma(out_luma)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Block contents by mode: 0 = raster ramp, 1 = negative ramp ending at -512, else a scrambled pattern.
    function automatic logic [9:0] val(input int m, input int r);
        if (m == 0) return 10'(r);
        if (m == 1) return r == 63 ? 10'h200 : 10'(-(r + 1));
        return 10'((m * 73 + r * 11) ^ (m << 7));
    endfunction

    function automatic logic lum(input int m);
        return m % 2 == 0;
    endfunction

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic write_rows(input int m, input int r0, input int r1);
        int n;
        for (int r = r0; r <= r1; r++) begin
            n = 0;
            in_valid = 1'b1;
            in_luma = r == 0 ? lum(m) : ~lum(m);
            for (int k = 0; k < 8; k++) in_row[k*10 +: 10] = val(m, r * 8 + k);
            while (!in_ready && n < 300) begin
                step();
                n++;
            end
            if (n == 300) chk("in_ready_timeout", in_ready, 1);
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic read_blocks(input int m0, input int nb, input bit rnd, input bit gap);
        int n;
        logic [9:0] e;
        for (int b = 0; b < nb; b++)
            for (int i = 0; i < 64; i++) begin
                n = 0;
                e = val(m0 + b, ZZ[i]);
                while (1) begin
                    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                    if (out_valid) begin
                        chk("rd_coeff", out_coeff, e);
                        chk("rd_index", out_index, i);
                        chk("rd_last", out_last, i == 63);
                        chk("rd_luma", out_luma, lum(m0 + b));
                        if (out_ready) break;
                    end else if (n == 300) begin
                        chk("out_valid_timeout", out_valid, 1);
                        break;
                    end
                    n++;
                    step();
                end
                if (gap && (b > 0 || i > 0)) chk("rd_gap", n, 0);
                step();
            end
        out_ready = 1'b0;
    endtask

    task automatic fill_tbl(input int m);
        tbl.delete();
        for (int i = 0; i < 64; i++) begin
            if (i % 16 == 5) tbl.push_back('{1'b0, val(m, ZZ[i]), 6'(i), 1'(i == 63)});
            tbl.push_back('{1'b1, val(m, ZZ[i]), 6'(i), 1'(i == 63)});
        end
    endtask

    task automatic run_tbl(input logic l);
        foreach (tbl[j]) begin
            out_ready = tbl[j].rdy;
            chk("tbl_valid", out_valid, 1);
            chk("tbl_coeff", out_coeff, tbl[j].coeff);
            chk("tbl_index", out_index, tbl[j].idx);
            chk("tbl_last", out_last, tbl[j].last);
            chk("tbl_luma", out_luma, l);
            step();
        end
        out_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_luma", out_luma, 0);
        reset = 1'b0;
        step();

        write_rows(0, 0, 7);
        chk("latency_valid", out_valid, 1);
        chk("latency_index", out_index, 0);
        fill_tbl(0);
        run_tbl(1'b1);
        chk("drained_valid", out_valid, 0);

        write_rows(1, 0, 7);
        fill_tbl(1);
        run_tbl(1'b0);

        fork
            begin
                write_rows(2, 0, 7);
                write_rows(3, 0, 7);
                write_rows(4, 0, 7);
            end
            read_blocks(2, 3, 1'b0, 1'b1);
        join

        fork
            for (int b = 5; b < 9; b++) write_rows(b, 0, 7);
            read_blocks(5, 4, 1'b1, 1'b0);
        join

        write_rows(9, 0, 7);
        write_rows(10, 0, 7);
        chk("both_full_ready", in_ready, 0);
        for (int i = 0; i < 63; i++) begin
            out_ready = 1'b1;
            chk("stall_pre_coeff", out_coeff, val(9, ZZ[i]));
            step();
        end
        out_ready = 1'b0;
        repeat (5) begin
            chk("stall_index", out_index, 63);
            chk("stall_last", out_last, 1);
            chk("stall_coeff", out_coeff, val(9, 63));
            chk("stall_in_ready", in_ready, 0);
            step();
        end
        out_ready = 1'b1;
        chk("release_in_ready_same", in_ready, 0);
        step();
        out_ready = 1'b0;
        chk("release_in_ready_next", in_ready, 1);
        chk("release_next_index", out_index, 0);
        chk("release_next_luma", out_luma, lum(10));
        read_blocks(10, 1, 1'b0, 1'b0);

        write_rows(12, 0, 7);
        write_rows(13, 0, 3);
        for (int i = 0; i < 20; i++) begin
            out_ready = 1'b1;
            step();
        end
        out_ready = 1'b0;
        chk("pre_reset_index", out_index, 20);
        chk("pre_reset_luma", out_luma, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_index", out_index, 0);
        chk("async_rst_last", out_last, 0);
        chk("async_rst_luma", out_luma, 0);
        chk("async_rst_ready", in_ready, 1);
        @(negedge clock);
        reset = 1'b0;
        step();
        write_rows(14, 0, 7);
        read_blocks(14, 1, 1'b0, 1'b0);
        chk("final_valid", out_valid, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
